// File: rtl/pcileech_sysctl.sv
// pcileech_sysctl: button conditioning, system reset sequencing, reload pulse, tick counter and power-on blink
module pcileech_sysctl #(
    parameter int PARAM_NUM_BTN         = 2,
    parameter int PARAM_DEBOUNCE_CYCLES = 1000000,
    parameter int PARAM_RST_CYCLES      = 64,
    parameter int PARAM_RELOAD_CYCLES   = 500000000,
    parameter int PARAM_BLINK_BIT       = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PARAM_NUM_BTN-1:0] btn_n,
    output logic [PARAM_NUM_BTN-1:0] btn_state,
    output logic [PARAM_NUM_BTN-1:0] btn_press,
    output logic [63:0]              tickcount,
    output logic                     rst_sys,
    output logic                     cfg_reload,
    output logic                     led_pwronblink
);
    localparam int DW = $clog2(PARAM_DEBOUNCE_CYCLES) + 1;
    localparam int HW = 32;
    localparam logic [DW-1:0] DEB_LAST    = DW'(PARAM_DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] RST_LAST    = HW'(PARAM_RST_CYCLES - 1);
    localparam logic [HW-1:0] RELOAD_MAX  = HW'(PARAM_RELOAD_CYCLES);
    localparam logic [HW-1:0] RELOAD_LAST = HW'(PARAM_RELOAD_CYCLES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HELD} state_t;

    logic [PARAM_NUM_BTN-1:0] sync1_q, sync2_q;
    logic [PARAM_NUM_BTN-1:0] state_q, state_d, state_dly_q, press_q;
    state_t                   fsm_q, fsm_d;
    logic [HW-1:0]            hold_q, hold_d;
    logic [63:0]              tick_q, tick_d;
    logic                     rst_sys_q, rst_sys_d;
    logic                     reload_q, reload_d;
    logic                     blink, inv;

    // two-flop synchroniser; idle (released) level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < PARAM_NUM_BTN; g++) begin : g_deb
        logic [DW-1:0] cnt_q, cnt_d;
        logic          differ, accept;
        assign differ     = (~sync2_q[g]) != state_q[g];
        assign accept     = differ && (cnt_q == DEB_LAST);
        assign cnt_d      = (!differ || accept) ? '0 : cnt_q + 1'b1;
        assign state_d[g] = accept ? ~state_q[g] : state_q[g];
        // stability counter: restarts whenever the input agrees with the accepted level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end
    end

    // accepted button levels and rising-edge pulse one cycle after the level rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            state_dly_q <= '0;
            press_q     <= '0;
        end else begin
            state_q     <= state_d;
            state_dly_q <= state_q;
            press_q     <= state_q & ~state_dly_q;
        end
    end

    // control state register with its counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= ST_INIT;
            hold_q    <= '0;
            tick_q    <= '0;
            rst_sys_q <= 1'b1;
            reload_q  <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            hold_q    <= hold_d;
            tick_q    <= tick_d;
            rst_sys_q <= rst_sys_d;
            reload_q  <= reload_d;
        end
    end

    // next state and hold counter; button-0 press always wins over INIT completion
    always_comb begin
        fsm_d  = fsm_q;
        hold_d = hold_q;
        case (fsm_q)
            ST_INIT: begin
                hold_d = hold_q + 1'b1;
                if (state_q[0]) begin
                    fsm_d  = ST_HELD;
                    hold_d = '0;
                end else if (hold_q == RST_LAST) begin
                    fsm_d  = ST_RUN;
                    hold_d = '0;
                end
            end
            ST_RUN: begin
                hold_d = '0;
                if (state_q[0]) fsm_d = ST_HELD;
            end
            ST_HELD: begin
                hold_d = (hold_q == RELOAD_MAX) ? hold_q : hold_q + 1'b1;
                if (!state_q[0]) begin
                    fsm_d  = ST_INIT;
                    hold_d = '0;
                end
            end
            default: begin
                fsm_d  = ST_INIT;
                hold_d = '0;
            end
        endcase
    end

    // outputs follow the next state so they line up with the registered state
    always_comb begin
        rst_sys_d = fsm_d != ST_RUN;
        reload_d  = (fsm_q == ST_HELD) && (hold_q == RELOAD_LAST);
        tick_d    = (fsm_d == ST_HELD) ? '0 : tick_q + 64'd1;
    end

    if (PARAM_NUM_BTN > 1) begin : g_inv
        assign inv = state_q[1];
    end else begin : g_noinv
        assign inv = 1'b0;
    end

    assign blink          = tick_q[PARAM_BLINK_BIT] & ~|tick_q[63:PARAM_BLINK_BIT+3];
    assign led_pwronblink = inv ^ blink;
    assign btn_state      = state_q;
    assign btn_press      = press_q;
    assign tickcount      = tick_q;
    assign rst_sys        = rst_sys_q;
    assign cfg_reload     = reload_q;
endmodule
